// File: rtl/pc_pkg.sv
// Shared constants and the next-PC source encoding for the program-counter generator.
package pc_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    // Return address skips the branch delay slot.
    localparam int unsigned RA_OFFSET   = 8;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0180;

    typedef enum logic [2:0] {
        SRC_EXC,
        SRC_REDIR,
        SRC_CALL,
        SRC_RET,
        SRC_SEQ,
        SRC_HOLD
    } pc_src_e;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side handshake, predecode hints and EX/exception redirects of the PC generator.
interface pc_gen_if #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

    logic [ADDR_W-1:0] pc_out;
    logic              pc_valid;
    logic              fetch_ready;
    logic              call_hint;
    logic [ADDR_W-1:0] call_target;
    logic              ret_hint;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              exc_valid;
    logic [CNT_W-1:0]  ras_count;

    // PC generator side.
    modport master (
        output pc_out, pc_valid, ras_count,
        input  fetch_ready, call_hint, call_target, ret_hint,
               redirect_valid, redirect_pc, exc_valid
    );

    // Fetch / pipeline side.
    modport slave (
        input  pc_out, pc_valid, ras_count,
        output fetch_ready, call_hint, call_target, ret_hint,
               redirect_valid, redirect_pc, exc_valid
    );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         pc_reset_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [ADDR_W-1:0]            push_addr,
    output logic [ADDR_W-1:0]            top,
    output logic [$clog2(DEPTH):0]       count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem [DEPTH];
    // ptr addresses the next free slot; top is the slot just below it.
    logic [PTR_W-1:0]  ptr;
    logic [CNT_W-1:0]  cnt;

    assign top   = mem[ptr - PTR_W'(1)];
    assign count = cnt;

    // Stack storage, pointer and saturating occupancy count.
    always_ff @(posedge clk or negedge pc_reset_n) begin
        if (!pc_reset_n) begin
            ptr <= '0;
            cnt <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push) begin
            mem[ptr] <= push_addr;
            ptr      <= ptr + PTR_W'(1);
            if (cnt != CNT_W'(DEPTH)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end else if (pop && cnt != '0) begin
            ptr <= ptr - PTR_W'(1);
            cnt <= cnt - CNT_W'(1);
        end
    end
endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: prioritised next-PC selection, fetch handshake and RAS prediction.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC),
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic       clk,
    input  logic       pc_reset_n,
    pc_gen_if.master   bus
);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q;
    logic              accept;
    pc_src_e           src;
    logic [ADDR_W-1:0] ras_top;
    logic [CNT_W-1:0]  ras_cnt;

    assign accept = valid_q & bus.fetch_ready;

    // Pick the next-PC source in priority order; hints only count on an accept.
    always_comb begin
        src = SRC_HOLD;
        if (bus.exc_valid) begin
            src = SRC_EXC;
        end else if (bus.redirect_valid) begin
            src = SRC_REDIR;
        end else if (accept) begin
            if (bus.call_hint) begin
                src = SRC_CALL;
            end else if (bus.ret_hint && ras_cnt != '0) begin
                src = SRC_RET;
            end else begin
                src = SRC_SEQ;
            end
        end
    end

    // Form the next PC; every loaded address is forced word-aligned.
    always_comb begin
        pc_d = pc_q;
        unique case (src)
            SRC_EXC:   pc_d = {EXC_VEC[ADDR_W-1:2], 2'b00};
            SRC_REDIR: pc_d = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
            SRC_CALL:  pc_d = {bus.call_target[ADDR_W-1:2], 2'b00};
            SRC_RET:   pc_d = {ras_top[ADDR_W-1:2], 2'b00};
            SRC_SEQ:   pc_d = pc_q + ADDR_W'(INSTR_BYTES);
            default:   pc_d = pc_q;
        endcase
    end

    // PC register; pc_valid rises on the first edge after reset release.
    always_ff @(posedge clk or negedge pc_reset_n) begin
        if (!pc_reset_n) begin
            pc_q    <= {RESET_VEC[ADDR_W-1:2], 2'b00};
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= 1'b1;
        end
    end

    pc_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk        (clk),
        .pc_reset_n (pc_reset_n),
        .push       (src == SRC_CALL),
        .pop        (src == SRC_RET),
        .flush      (src == SRC_EXC),
        .push_addr  (pc_q + ADDR_W'(RA_OFFSET)),
        .top        (ras_top),
        .count      (ras_cnt)
    );

    assign bus.pc_out    = pc_q;
    assign bus.pc_valid  = valid_q;
    assign bus.ras_count = ras_cnt;
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with hand-computed expected PCs and RAS counts.
module tb_pc_gen;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    pc_gen_if #(.ADDR_W(32), .RAS_DEPTH(4)) bus ();

    pc_gen #(.ADDR_W(32), .RAS_DEPTH(4)) dut (
        .clk        (clk),
        .pc_reset_n (rst_n),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic [31:0] addr);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = addr;
        step();
        bus.redirect_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] pc, input logic [31:0] cnt);
        check_eq({tag, " pc"}, bus.pc_out, pc);
        check_eq({tag, " cnt"}, 32'(bus.ras_count), cnt);
    endtask

    initial begin
        logic [31:0] ret_exp [5];
        logic [31:0] cnt_exp [5];
        ret_exp = '{32'h5008, 32'h4008, 32'h3008, 32'h2008, 32'h200C};
        cnt_exp = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0};

        rst_n              = 1'b0;
        bus.fetch_ready    = 1'b0;
        bus.call_hint      = 1'b0;
        bus.call_target    = '0;
        bus.ret_hint       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.exc_valid      = 1'b0;
        repeat (2) step();
        chk("reset", 32'h0, 32'd0);
        check_eq("reset valid", 32'(bus.pc_valid), 32'd0);

        // Release with fetch ready: valid rises, then sequential fetch.
        rst_n           = 1'b1;
        bus.fetch_ready = 1'b1;
        step();
        check_eq("valid rise", 32'(bus.pc_valid), 32'd1);
        check_eq("seq0", bus.pc_out, 32'h0);
        step(); check_eq("seq4", bus.pc_out, 32'h4);
        step(); check_eq("seq8", bus.pc_out, 32'h8);
        step(); check_eq("seqC", bus.pc_out, 32'hC);
        step(); check_eq("seq10", bus.pc_out, 32'h10);

        // Stall holds the PC.
        bus.fetch_ready = 1'b0;
        step(); check_eq("hold1", bus.pc_out, 32'h10);
        step(); check_eq("hold2", bus.pc_out, 32'h10);
        bus.fetch_ready = 1'b1;
        step(); check_eq("after hold", bus.pc_out, 32'h14);
        bus.fetch_ready = 1'b0;

        // Call then return.
        redir(32'h100);
        chk("redir100", 32'h100, 32'd0);
        bus.fetch_ready = 1'b1;
        bus.call_hint   = 1'b1;
        bus.call_target = 32'h400;
        step(); chk("call", 32'h400, 32'd1);
        bus.call_hint = 1'b0;
        bus.ret_hint  = 1'b1;
        step(); chk("ret", 32'h108, 32'd0);
        bus.ret_hint = 1'b0;
        step(); chk("post ret", 32'h10C, 32'd0);
        bus.fetch_ready = 1'b0;

        // Overflow: five calls into a four-entry stack, then five returns.
        redir(32'h1000);
        bus.fetch_ready = 1'b1;
        bus.call_hint   = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            bus.call_target = 32'(i + 1) * 32'h1000;
            step();
            chk($sformatf("ovf call%0d", i), 32'(i + 1) * 32'h1000, (i > 4) ? 32'd4 : 32'(i));
        end
        bus.call_hint = 1'b0;
        bus.ret_hint  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("ovf ret%0d", i), ret_exp[i], cnt_exp[i]);
        end
        bus.ret_hint = 1'b0;

        // Exception beats redirect and a simultaneous call; RAS flushed.
        bus.call_hint   = 1'b1;
        bus.call_target = 32'h7000;
        step(); chk("pre-exc call", 32'h7000, 32'd1);
        bus.exc_valid      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h2000;
        bus.call_target    = 32'h9000;
        step(); chk("exc", 32'h8000_0180, 32'd0);
        bus.exc_valid      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.call_hint      = 1'b0;
        bus.fetch_ready    = 1'b0;
        step(); chk("exc hold", 32'h8000_0180, 32'd0);

        // Call and return hints together act as a call; misaligned target aligned.
        redir(32'h500);
        bus.fetch_ready = 1'b1;
        bus.call_hint   = 1'b1;
        bus.ret_hint    = 1'b1;
        bus.call_target = 32'h601;
        step(); chk("call+ret", 32'h600, 32'd1);
        bus.call_hint = 1'b0;
        step(); chk("ret 508", 32'h508, 32'd0);
        bus.ret_hint    = 1'b0;
        bus.fetch_ready = 1'b0;

        // Alignment and wraparound.
        redir(32'h0000_3003);
        check_eq("align redir", bus.pc_out, 32'h3000);
        redir(32'hFFFF_FFFC);
        check_eq("redir top", bus.pc_out, 32'hFFFF_FFFC);
        bus.fetch_ready = 1'b1;
        step(); check_eq("wrap", bus.pc_out, 32'h0);

        // Asynchronous reset mid-stream with a pending redirect.
        bus.call_hint   = 1'b1;
        bus.call_target = 32'h800;
        step(); chk("pre-rst call", 32'h800, 32'd1);
        bus.call_hint      = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h4444;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst", 32'h0, 32'd0);
        check_eq("async rst valid", 32'(bus.pc_valid), 32'd0);
        bus.redirect_valid = 1'b0;
        bus.fetch_ready    = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("post rst", 32'h0, 32'd0);
        check_eq("post rst valid", 32'(bus.pc_valid), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
